// File: rtl/regfile_dbg_arb_if.sv
// Signal bundle between the LC-3 core control, the debug requester, the arbiter
// and the 8x16 register file. The arbiter takes the slave side.
interface regfile_dbg_arb_if;
    logic        core_ld_reg;
    logic [1:0]  core_dr_mux;
    logic [1:0]  core_sr1_mux;
    logic [11:0] core_ir_slice;
    logic [15:0] core_bus;
    logic        core_at_fetch;
    logic        core_stall;
    logic        core_viol;

    logic        dbg_req;
    logic        dbg_we;
    logic [2:0]  dbg_idx;
    logic [15:0] dbg_wdata;
    logic        dbg_ack;
    logic [15:0] dbg_rdata;

    logic        rf_ld_reg;
    logic [1:0]  rf_dr_mux;
    logic [1:0]  rf_sr1_mux;
    logic [11:0] rf_ir_slice;
    logic [15:0] rf_bus;
    logic [15:0] rf_sr1_in;

    modport master (
        output core_ld_reg, core_dr_mux, core_sr1_mux, core_ir_slice, core_bus, core_at_fetch,
        input  core_stall, core_viol,
        output dbg_req, dbg_we, dbg_idx, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  rf_ld_reg, rf_dr_mux, rf_sr1_mux, rf_ir_slice, rf_bus,
        output rf_sr1_in
    );

    modport slave (
        input  core_ld_reg, core_dr_mux, core_sr1_mux, core_ir_slice, core_bus, core_at_fetch,
        output core_stall, core_viol,
        input  dbg_req, dbg_we, dbg_idx, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output rf_ld_reg, rf_dr_mux, rf_sr1_mux, rf_ir_slice, rf_bus,
        input  rf_sr1_in
    );
endinterface

// File: rtl/regfile_dbg_arb.sv
// Shares the LC-3 register-file write port and SR1 read port between the core
// control FSM and a debug requester; debug accesses are granted at fetch boundaries.
module regfile_dbg_arb #(
    parameter int unsigned STALL_CYC    = 2,
    parameter int unsigned MIN_CORE_GAP = 4
) (
    input logic            clk,
    input logic            rst,
    regfile_dbg_arb_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STALL  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    localparam logic [3:0] STALL_LOAD = 4'(STALL_CYC - 1);
    localparam logic [3:0] GAP_LOAD   = 4'(MIN_CORE_GAP);

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  stall_cnt_r;
    logic [3:0]  gap_cnt_r;
    logic [15:0] dbg_rdata_r;
    logic        core_viol_r;
    logic        grant_s;

    logic        core_stall_s;
    logic        dbg_ack_s;
    logic        rf_ld_reg_s;
    logic [1:0]  rf_dr_mux_s;
    logic [1:0]  rf_sr1_mux_s;
    logic [11:0] rf_ir_slice_s;
    logic [15:0] rf_bus_s;

    assign grant_s = bus.dbg_req && bus.core_at_fetch && (gap_cnt_r == 4'd0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a dropped request during the drain aborts without an access
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_next_s = ST_STALL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (!bus.dbg_req) begin
                    state_next_s = ST_IDLE;
                end else if (stall_cnt_r == 4'd0) begin
                    state_next_s = ST_ACCESS;
                end else begin
                    state_next_s = ST_STALL;
                end
            end
            ST_ACCESS: state_next_s = ST_ACK;
            ST_ACK:    state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Drain/gap counters, read capture and the sticky lockout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 4'd0;
            gap_cnt_r   <= 4'd0;
            dbg_rdata_r <= 16'd0;
            core_viol_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        stall_cnt_r <= STALL_LOAD;
                    end
                    if (gap_cnt_r != 4'd0) begin
                        gap_cnt_r <= gap_cnt_r - 4'd1;
                    end
                end
                ST_STALL: begin
                    if (stall_cnt_r != 4'd0) begin
                        stall_cnt_r <= stall_cnt_r - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    if (!bus.dbg_we) begin
                        dbg_rdata_r <= bus.rf_sr1_in;
                    end
                end
                ST_ACK:  gap_cnt_r <= GAP_LOAD;
                default: gap_cnt_r <= gap_cnt_r;
            endcase
            if (((state_r == ST_ACCESS) || (state_r == ST_ACK)) && bus.core_ld_reg) begin
                core_viol_r <= 1'b1;
            end
        end
    end

    // Outputs: core pass-through except while the debug addressing owns the file
    always_comb begin
        core_stall_s  = 1'b0;
        dbg_ack_s     = 1'b0;
        rf_ld_reg_s   = bus.core_ld_reg;
        rf_dr_mux_s   = bus.core_dr_mux;
        rf_sr1_mux_s  = bus.core_sr1_mux;
        rf_ir_slice_s = bus.core_ir_slice;
        rf_bus_s      = bus.core_bus;
        case (state_r)
            ST_IDLE: begin
                core_stall_s = 1'b0;
            end
            ST_STALL: begin
                core_stall_s = 1'b1;
            end
            ST_ACCESS, ST_ACK: begin
                core_stall_s  = 1'b1;
                dbg_ack_s     = (state_r == ST_ACK);
                rf_dr_mux_s   = 2'b00;
                rf_sr1_mux_s  = 2'b00;
                rf_ir_slice_s = {bus.dbg_idx, 9'd0};
                if (bus.dbg_we) begin
                    rf_bus_s    = bus.dbg_wdata;
                    rf_ld_reg_s = (state_r == ST_ACCESS);
                end else begin
                    rf_bus_s    = 16'd0;
                    rf_ld_reg_s = 1'b0;
                end
            end
            default: begin
                core_stall_s = 1'b0;
            end
        endcase
    end

    assign bus.core_stall  = core_stall_s;
    assign bus.core_viol   = core_viol_r;
    assign bus.dbg_ack     = dbg_ack_s;
    assign bus.dbg_rdata   = dbg_rdata_r;
    assign bus.rf_ld_reg   = rf_ld_reg_s;
    assign bus.rf_dr_mux   = rf_dr_mux_s;
    assign bus.rf_sr1_mux  = rf_sr1_mux_s;
    assign bus.rf_ir_slice = rf_ir_slice_s;
    assign bus.rf_bus      = rf_bus_s;
endmodule

// File: tb/tb_regfile_dbg_arb.sv
// Bench for regfile_dbg_arb: LC-3 register file environment, timeline-based
// reference model checked every cycle, plus directed scenarios with literal values.
module tb_regfile_dbg_arb;
    localparam int S = 2;
    localparam int G = 4;

    logic clk = 1'b0;
    logic rst;
    logic rf_init;
    logic chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    regfile_dbg_arb_if ifc ();

    regfile_dbg_arb #(.STALL_CYC(S), .MIN_CORE_GAP(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] dr_dest(input logic [1:0] m, input logic [11:0] ir);
        if (m == 2'b00) return ir[11:9];
        else if (m == 2'b01) return 3'd6;
        else return 3'd7;
    endfunction

    function automatic logic [2:0] sr1_src(input logic [1:0] m, input logic [11:0] ir);
        if (m == 2'b00) return ir[11:9];
        else if (m == 2'b01) return ir[8:6];
        else return 3'd6;
    endfunction

    // Environment: the 8x16 register file driven by the DUT's rf_* outputs
    logic [15:0] rf_mem [8];
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 16'd0;
        end else if (ifc.rf_ld_reg) begin
            rf_mem[dr_dest(ifc.rf_dr_mux, ifc.rf_ir_slice)] <= ifc.rf_bus;
        end
    end
    always_comb ifc.rf_sr1_in = rf_mem[sr1_src(ifc.rf_sr1_mux, ifc.rf_ir_slice)];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a granted access is a timeline offset from its grant cycle
    int          m_cyc = 0;
    int          m_grant = -1;
    int          m_last_ack = -1000;
    logic [15:0] m_regs [8];
    logic [15:0] m_rdata = 16'd0;
    logic        m_viol = 1'b0;

    always @(negedge clk) begin : model
        int          ph;
        logic        e_stl, e_acc, e_ack, e_busy, e_deb, e_ld;
        logic [1:0]  e_dr, e_sr1;
        logic [11:0] e_ir;
        logic [15:0] e_bus;
        ph     = (m_grant >= 0) ? (m_cyc - m_grant) : 0;
        e_stl  = (ph >= 1) && (ph <= S);
        e_acc  = (ph == S + 1);
        e_ack  = (ph == S + 2);
        e_busy = (ph >= 1);
        e_deb  = e_acc || e_ack;
        e_ld   = e_acc ? ifc.dbg_we : (e_ack ? 1'b0 : ifc.core_ld_reg);
        e_dr   = e_deb ? 2'b00 : ifc.core_dr_mux;
        e_sr1  = e_deb ? 2'b00 : ifc.core_sr1_mux;
        e_ir   = e_deb ? {ifc.dbg_idx, 9'd0} : ifc.core_ir_slice;
        e_bus  = e_acc ? (ifc.dbg_we ? ifc.dbg_wdata : 16'd0) : ifc.core_bus;
        if (chk_en) begin
            check("m_core_stall", 16'(ifc.core_stall), 16'(e_busy));
            check("m_dbg_ack", 16'(ifc.dbg_ack), 16'(e_ack));
            check("m_rf_ld_reg", 16'(ifc.rf_ld_reg), 16'(e_ld));
            check("m_rf_dr_mux", 16'(ifc.rf_dr_mux), 16'(e_dr));
            check("m_rf_sr1_mux", 16'(ifc.rf_sr1_mux), 16'(e_sr1));
            check("m_rf_ir_slice", 16'(ifc.rf_ir_slice), 16'(e_ir));
            if (!e_ack) check("m_rf_bus", ifc.rf_bus, e_bus);
            check("m_dbg_rdata", ifc.dbg_rdata, m_rdata);
            check("m_core_viol", 16'(ifc.core_viol), 16'(m_viol));
            check("m_rf_sr1_in", ifc.rf_sr1_in, m_regs[sr1_src(e_sr1, e_ir)]);
        end
        if (rst) begin
            m_grant = -1; m_last_ack = -1000; m_rdata = 16'd0; m_viol = 1'b0;
        end else begin
            if (e_acc && !ifc.dbg_we) m_rdata = m_regs[ifc.dbg_idx];
            if (e_deb && ifc.core_ld_reg) m_viol = 1'b1;
            if (!e_busy) begin
                if (ifc.dbg_req && ifc.core_at_fetch && (m_cyc > m_last_ack + G)) m_grant = m_cyc;
            end else if (e_stl && !ifc.dbg_req) begin
                m_grant = -1;
            end else if (e_ack) begin
                m_grant = -1; m_last_ack = m_cyc;
            end
        end
        if (rf_init) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
        end else if (e_ld) begin
            m_regs[dr_dest(e_dr, e_ir)] = e_bus;
        end
        m_cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_ack(input string nm, output int waited);
        waited = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifc.dbg_ack) begin
                waited = i;
                break;
            end
            tick();
        end
        if (waited < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: no dbg_ack within 40 cycles", nm);
        end
    endtask

    initial begin
        int w;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1; rf_init = 1'b1;
        ifc.core_ld_reg = 1'b0; ifc.core_dr_mux = 2'b00; ifc.core_sr1_mux = 2'b00;
        ifc.core_ir_slice = 12'h000; ifc.core_bus = 16'h0000; ifc.core_at_fetch = 1'b1;
        ifc.dbg_req = 1'b0; ifc.dbg_we = 1'b0; ifc.dbg_idx = 3'd0; ifc.dbg_wdata = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        check("rst_core_stall", 16'(ifc.core_stall), 16'd0);
        check("rst_dbg_ack", 16'(ifc.dbg_ack), 16'd0);
        check("rst_dbg_rdata", ifc.dbg_rdata, 16'd0);
        check("rst_core_viol", 16'(ifc.core_viol), 16'd0);
        tick();
        rst = 1'b0; rf_init = 1'b0; chk_en = 1'b1;

        // Pass-through write to R6, then read it back through SR1
        ifc.core_ld_reg = 1'b1; ifc.core_dr_mux = 2'b01; ifc.core_bus = 16'h1234;
        @(negedge clk);
        check("pt_rf_ld_reg", 16'(ifc.rf_ld_reg), 16'd1);
        check("pt_rf_dr_mux", 16'(ifc.rf_dr_mux), 16'd1);
        check("pt_rf_bus", ifc.rf_bus, 16'h1234);
        check("pt_core_stall", 16'(ifc.core_stall), 16'd0);
        tick();
        ifc.core_ld_reg = 1'b0; ifc.core_sr1_mux = 2'b10;
        @(negedge clk);
        check("pt_r6", ifc.rf_sr1_in, 16'h1234);
        tick();
        ifc.core_sr1_mux = 2'b00; ifc.core_dr_mux = 2'b00;

        // Debug write R5 = BEEF, then read it back
        ifc.dbg_req = 1'b1; ifc.dbg_we = 1'b1; ifc.dbg_idx = 3'd5; ifc.dbg_wdata = 16'hBEEF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("wr_core_stall", 16'(ifc.core_stall), 16'((c >= 1) && (c <= 4)));
            check("wr_dbg_ack", 16'(ifc.dbg_ack), 16'(c == 4));
            if (c == 3) begin
                check("wr_rf_ld_reg", 16'(ifc.rf_ld_reg), 16'd1);
                check("wr_rf_ir_slice", 16'(ifc.rf_ir_slice), 16'h0A00);
            end
            if (c == 4) check("wr_visible", ifc.rf_sr1_in, 16'hBEEF);
            tick();
            if (c == 4) ifc.dbg_req = 1'b0;
        end
        ifc.dbg_req = 1'b1; ifc.dbg_we = 1'b0; ifc.dbg_wdata = 16'h0000;
        wait_ack("rd_ack", w);
        check("rd_dbg_rdata", ifc.dbg_rdata, 16'hBEEF);
        tick();
        ifc.dbg_req = 1'b0;
        idle(6);

        // Boundary gating: request waits while the core is not at fetch
        ifc.dbg_req = 1'b1; ifc.dbg_we = 1'b1; ifc.dbg_idx = 3'd2; ifc.dbg_wdata = 16'h0A0A;
        ifc.core_at_fetch = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            check("gate_core_stall", 16'(ifc.core_stall), 16'((c >= 11) && (c <= 14)));
            check("gate_dbg_ack", 16'(ifc.dbg_ack), 16'(c == 14));
            tick();
            if (c == 9) ifc.core_at_fetch = 1'b1;
            if (c == 14) ifc.dbg_req = 1'b0;
        end
        idle(6);

        // Abort in the first drain cycle, immediate regrant, then a held back-to-back request
        ifc.dbg_req = 1'b1; ifc.dbg_we = 1'b1; ifc.dbg_idx = 3'd1; ifc.dbg_wdata = 16'h1111;
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            check("ab_core_stall", 16'(ifc.core_stall),
                  16'((c == 1) || ((c >= 4) && (c <= 7)) || ((c >= 13) && (c <= 16))));
            check("ab_dbg_ack", 16'(ifc.dbg_ack), 16'((c == 7) || (c == 16)));
            tick();
            if (c == 0) ifc.dbg_req = 1'b0;
            if (c == 2) ifc.dbg_req = 1'b1;
            if (c == 16) ifc.dbg_req = 1'b0;
        end
        idle(6);

        // Core write in the grant cycle passes; core write during ACCESS is blocked
        ifc.dbg_req = 1'b1; ifc.dbg_we = 1'b1; ifc.dbg_idx = 3'd3; ifc.dbg_wdata = 16'h5A5A;
        ifc.core_ld_reg = 1'b1; ifc.core_dr_mux = 2'b10; ifc.core_bus = 16'h0707;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("vi_grant_ld", 16'(ifc.rf_ld_reg), 16'd1);
                check("vi_grant_bus", ifc.rf_bus, 16'h0707);
            end
            if (c == 3) begin
                check("vi_acc_ld", 16'(ifc.rf_ld_reg), 16'd1);
                check("vi_acc_bus", ifc.rf_bus, 16'h5A5A);
                check("vi_acc_ir", 16'(ifc.rf_ir_slice), 16'h0600);
            end
            check("vi_core_viol", 16'(ifc.core_viol), 16'(c >= 4));
            tick();
            if (c == 0) ifc.core_ld_reg = 1'b0;
            if (c == 2) begin
                ifc.core_ld_reg = 1'b1; ifc.core_dr_mux = 2'b00;
                ifc.core_ir_slice = 12'h200; ifc.core_bus = 16'hDEAD;
            end
            if (c == 3) begin
                ifc.core_ld_reg = 1'b0; ifc.core_ir_slice = 12'h000;
            end
            if (c == 4) ifc.dbg_req = 1'b0;
        end
        check("vi_r1_kept", rf_mem[1], 16'h1111);
        check("vi_r7", rf_mem[7], 16'h0707);
        check("vi_r3", rf_mem[3], 16'h5A5A);
        idle(6);

        // Reset during the drain: back to IDLE with reset values, target untouched
        ifc.dbg_req = 1'b1; ifc.dbg_we = 1'b1; ifc.dbg_idx = 3'd4; ifc.dbg_wdata = 16'h7777;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 1) check("rs_in_stall", 16'(ifc.core_stall), 16'd1);
            if (c >= 2) begin
                check("rs_core_stall", 16'(ifc.core_stall), 16'd0);
                check("rs_dbg_ack", 16'(ifc.dbg_ack), 16'd0);
                check("rs_dbg_rdata", ifc.dbg_rdata, 16'd0);
                check("rs_core_viol", 16'(ifc.core_viol), 16'd0);
            end
            tick();
            if (c == 0) rst = 1'b1;
            if (c == 1) begin
                rst = 1'b0; ifc.dbg_req = 1'b0;
            end
        end
        check("rs_r4_kept", rf_mem[4], 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
